// File: rtl/lcd_nibble_receiver_if.sv
// HD44780-style 4-bit LCD write bus (E, RS, RW, D[7:4]) between the LCD
// controller (master) and the nibble receiver (slave).
interface lcd_nibble_receiver_if;
  logic       iLCD_Enabled;
  logic       iLCD_RegisterSelect;
  logic       iLCD_ReadWrite;
  logic [3:0] iLCD_Data;

  modport master (
    output iLCD_Enabled,
    output iLCD_RegisterSelect,
    output iLCD_ReadWrite,
    output iLCD_Data
  );

  modport slave (
    input iLCD_Enabled,
    input iLCD_RegisterSelect,
    input iLCD_ReadWrite,
    input iLCD_Data
  );
endinterface

// File: rtl/lcd_nibble_receiver.sv
// Responder for the 4-bit LCD write bus: follows the power-on init sequence,
// rebuilds bytes from nibble pairs, shadows display state and flags misuse.
module lcd_nibble_receiver #(
  parameter int PWRUP_CYCLES = 16,
  parameter int CMD_CYCLES   = 2,
  parameter int CLEAR_CYCLES = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lcd_nibble_receiver_if.slave lcd_bus,
  output logic                 oByteValid,
  output logic [7:0]           oByte,
  output logic                 oIsData,
  output logic                 oInitDone,
  output logic                 oTwoLine,
  output logic                 oDisplayOn,
  output logic                 oCursorOn,
  output logic                 oBlinkOn,
  output logic                 oIncrement,
  output logic                 oShift,
  output logic [6:0]           oDDRAMAddr,
  output logic                 oBusy,
  output logic [3:0]           oErrorFlags
);

  localparam int MAX_A   = (PWRUP_CYCLES > CLEAR_CYCLES) ? PWRUP_CYCLES : CLEAR_CYCLES;
  localparam int MAX_CYC = (MAX_A > CMD_CYCLES) ? MAX_A : CMD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  localparam int ERR_EARLY = 0;
  localparam int ERR_BUSY  = 1;
  localparam int ERR_READ  = 2;
  localparam int ERR_SEQ   = 3;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT3A,
    S_INIT3B,
    S_INIT3C,
    S_INIT2,
    S_HIGH,
    S_LOW
  } state_t;

  state_t           r_state, w_state_nxt;

  logic             r_e_q;
  logic             r_rs_q;
  logic             r_rw_q;
  logic [3:0]       r_d_q;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_hi_nib, w_hi_nib_nxt;
  logic             r_hi_rs, w_hi_rs_nxt;

  logic             r_byte_valid, w_byte_valid_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             r_is_data, w_is_data_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             r_two_line, w_two_line_nxt;
  logic             r_disp_on, w_disp_on_nxt;
  logic             r_cursor_on, w_cursor_on_nxt;
  logic             r_blink_on, w_blink_on_nxt;
  logic             r_incr, w_incr_nxt;
  logic             r_shift, w_shift_nxt;
  logic [6:0]       r_addr, w_addr_nxt;
  logic [3:0]       r_err, w_err_nxt;

  logic             w_strobe;
  logic             w_busy;
  logic             w_init3;
  logic [7:0]       w_byte_asm;

  // Falling edge of E: the bus fields captured during the last E-high cycle apply.
  assign w_strobe   = r_e_q & ~lcd_bus.iLCD_Enabled;
  assign w_busy     = (r_cnt != '0);
  assign w_init3    = ~r_rs_q & (r_d_q == 4'h3);
  assign w_byte_asm = {r_hi_nib, r_d_q};

  always_comb begin
    // NOTE: every next value defaults to holding its register, so no branch can infer a latch.
    w_state_nxt      = r_state;
    w_cnt_nxt        = w_busy ? (r_cnt - CNT_W'(1)) : r_cnt;
    w_hi_nib_nxt     = r_hi_nib;
    w_hi_rs_nxt      = r_hi_rs;
    w_byte_valid_nxt = 1'b0;
    w_byte_nxt       = r_byte;
    w_is_data_nxt    = r_is_data;
    w_init_done_nxt  = r_init_done;
    w_two_line_nxt   = r_two_line;
    w_disp_on_nxt    = r_disp_on;
    w_cursor_on_nxt  = r_cursor_on;
    w_blink_on_nxt   = r_blink_on;
    w_incr_nxt       = r_incr;
    w_shift_nxt      = r_shift;
    w_addr_nxt       = r_addr;
    w_err_nxt        = r_err;

    if (r_state == S_PWRUP && !w_busy) begin
      w_state_nxt = S_INIT3A;
    end

    if (w_strobe) begin
      if (r_rw_q) begin
        w_err_nxt[ERR_READ] = 1'b1;
      end else if (r_state == S_PWRUP) begin
        if (w_busy) begin
          w_err_nxt[ERR_EARLY] = 1'b1;
        end
      end else begin
        if (w_busy) begin
          w_err_nxt[ERR_BUSY] = 1'b1;
        end
        case (r_state)
          S_INIT3A, S_INIT3B, S_INIT3C: begin
            if (w_init3) begin
              w_cnt_nxt = CMD_LOAD;
              if (r_state == S_INIT3A) begin
                w_state_nxt = S_INIT3B;
              end else if (r_state == S_INIT3B) begin
                w_state_nxt = S_INIT3C;
              end else begin
                w_state_nxt = S_INIT2;
              end
            end else begin
              w_err_nxt[ERR_SEQ] = 1'b1;
              w_state_nxt        = S_INIT3A;
            end
          end
          S_INIT2: begin
            if (!r_rs_q && r_d_q == 4'h2) begin
              w_cnt_nxt       = CMD_LOAD;
              w_init_done_nxt = 1'b1;
              w_state_nxt     = S_HIGH;
            end else if (w_init3) begin
              w_cnt_nxt = CMD_LOAD;
            end else begin
              w_err_nxt[ERR_SEQ] = 1'b1;
              w_state_nxt        = S_INIT3A;
            end
          end
          S_HIGH: begin
            w_hi_nib_nxt = r_d_q;
            w_hi_rs_nxt  = r_rs_q;
            w_state_nxt  = S_LOW;
          end
          S_LOW: begin
            w_byte_valid_nxt = 1'b1;
            w_byte_nxt       = w_byte_asm;
            w_is_data_nxt    = r_hi_rs;
            w_cnt_nxt        = CMD_LOAD;
            w_state_nxt      = S_HIGH;
            if (r_rs_q != r_hi_rs) begin
              w_err_nxt[ERR_SEQ] = 1'b1;
            end
            if (r_hi_rs) begin
              w_addr_nxt = r_incr ? (r_addr + 7'd1) : (r_addr - 7'd1);
            end else begin
              // Highest set bit selects the instruction.
              casez (w_byte_asm)
                8'b1???????: w_addr_nxt = w_byte_asm[6:0];
                8'b01??????: ;
                8'b001?????: begin
                  w_two_line_nxt = w_byte_asm[3];
                  if (w_byte_asm[4]) begin
                    w_err_nxt[ERR_SEQ] = 1'b1;
                  end
                end
                8'b0001????: begin
                  if (!w_byte_asm[3]) begin
                    w_addr_nxt = w_byte_asm[2] ? (r_addr + 7'd1) : (r_addr - 7'd1);
                  end
                end
                8'b00001???: begin
                  w_disp_on_nxt   = w_byte_asm[2];
                  w_cursor_on_nxt = w_byte_asm[1];
                  w_blink_on_nxt  = w_byte_asm[0];
                end
                8'b000001??: begin
                  w_incr_nxt  = w_byte_asm[1];
                  w_shift_nxt = w_byte_asm[0];
                end
                8'b0000001?: begin
                  w_addr_nxt = 7'd0;
                  w_cnt_nxt  = CLEAR_LOAD;
                end
                8'b00000001: begin
                  w_addr_nxt = 7'd0;
                  w_incr_nxt = 1'b1;
                  w_cnt_nxt  = CLEAR_LOAD;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      r_state      <= S_PWRUP;
      r_e_q        <= 1'b0;
      r_rs_q       <= 1'b0;
      r_rw_q       <= 1'b0;
      r_d_q        <= 4'h0;
      r_cnt        <= PWRUP_LOAD;
      r_hi_nib     <= 4'h0;
      r_hi_rs      <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
      r_is_data    <= 1'b0;
      r_init_done  <= 1'b0;
      r_two_line   <= 1'b0;
      r_disp_on    <= 1'b0;
      r_cursor_on  <= 1'b0;
      r_blink_on   <= 1'b0;
      r_incr       <= 1'b1;
      r_shift      <= 1'b0;
      r_addr       <= 7'd0;
      r_err        <= 4'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_e_q        <= lcd_bus.iLCD_Enabled;
      r_rs_q       <= lcd_bus.iLCD_RegisterSelect;
      r_rw_q       <= lcd_bus.iLCD_ReadWrite;
      r_d_q        <= lcd_bus.iLCD_Data;
      r_cnt        <= w_cnt_nxt;
      r_hi_nib     <= w_hi_nib_nxt;
      r_hi_rs      <= w_hi_rs_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_byte       <= w_byte_nxt;
      r_is_data    <= w_is_data_nxt;
      r_init_done  <= w_init_done_nxt;
      r_two_line   <= w_two_line_nxt;
      r_disp_on    <= w_disp_on_nxt;
      r_cursor_on  <= w_cursor_on_nxt;
      r_blink_on   <= w_blink_on_nxt;
      r_incr       <= w_incr_nxt;
      r_shift      <= w_shift_nxt;
      r_addr       <= w_addr_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign oByteValid  = r_byte_valid;
  assign oByte       = r_byte;
  assign oIsData     = r_is_data;
  assign oInitDone   = r_init_done;
  assign oTwoLine    = r_two_line;
  assign oDisplayOn  = r_disp_on;
  assign oCursorOn   = r_cursor_on;
  assign oBlinkOn    = r_blink_on;
  assign oIncrement  = r_incr;
  assign oShift      = r_shift;
  assign oDDRAMAddr  = r_addr;
  assign oBusy       = w_busy;
  assign oErrorFlags = r_err;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed bench for lcd_nibble_receiver: init sequence, command decode,
// address wrap, busy/read/sequence errors and reset between nibbles.
module tb_lcd_nibble_receiver;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       oByteValid;
  logic [7:0] oByte;
  logic       oIsData;
  logic       oInitDone;
  logic       oTwoLine;
  logic       oDisplayOn;
  logic       oCursorOn;
  logic       oBlinkOn;
  logic       oIncrement;
  logic       oShift;
  logic [6:0] oDDRAMAddr;
  logic       oBusy;
  logic [3:0] oErrorFlags;

  int n_cmp = 0;
  int n_mis = 0;

  lcd_nibble_receiver_if lcd_bus ();

  lcd_nibble_receiver #(
    .PWRUP_CYCLES (16),
    .CMD_CYCLES   (2),
    .CLEAR_CYCLES (8)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .lcd_bus     (lcd_bus),
    .oByteValid  (oByteValid),
    .oByte       (oByte),
    .oIsData     (oIsData),
    .oInitDone   (oInitDone),
    .oTwoLine    (oTwoLine),
    .oDisplayOn  (oDisplayOn),
    .oCursorOn   (oCursorOn),
    .oBlinkOn    (oBlinkOn),
    .oIncrement  (oIncrement),
    .oShift      (oShift),
    .oDDRAMAddr  (oDDRAMAddr),
    .oBusy       (oBusy),
    .oErrorFlags (oErrorFlags)
  );

  always #5 Clock = ~Clock;

  // Config commands and the DDRAM address expected after each.
  localparam logic [7:0] CFG_BYTE [5] = '{8'h28, 8'h0C, 8'h06, 8'h85, 8'h01};
  localparam logic [6:0] CFG_ADDR [5] = '{7'h00, 7'h00, 7'h00, 7'h05, 7'h00};

  // Wrap vectors: RS, byte, expected address, expected increment flag.
  localparam logic       WR_RS   [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] WR_BYTE [9] = '{8'hFF, 8'h41, 8'h04, 8'h42, 8'h06, 8'h14, 8'h10, 8'h18, 8'h20};
  localparam logic [6:0] WR_ADDR [9] = '{7'h7F, 7'h00, 7'h00, 7'h7F, 7'h7F, 7'h00, 7'h7F, 7'h7F, 7'h00};
  localparam logic       WR_INC  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic send_nibble(input logic rs, input logic rw, input logic [3:0] d);
    lcd_bus.iLCD_Enabled        = 1'b1;
    lcd_bus.iLCD_RegisterSelect = rs;
    lcd_bus.iLCD_ReadWrite      = rw;
    lcd_bus.iLCD_Data           = d;
    tick(1);
    lcd_bus.iLCD_Enabled = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nibble(rs, 1'b0, b[7:4]);
    send_nibble(rs, 1'b0, b[3:0]);
  endtask

  task automatic do_reset();
    Reset                       = 1'b1;
    lcd_bus.iLCD_Enabled        = 1'b0;
    lcd_bus.iLCD_RegisterSelect = 1'b0;
    lcd_bus.iLCD_ReadWrite      = 1'b0;
    lcd_bus.iLCD_Data           = 4'h0;
    tick(1);
    Reset = 1'b0;
  endtask

  task automatic init_seq();
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h2); tick(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({oByteValid, oByte, oIsData, oInitDone, oTwoLine, oDisplayOn, oCursorOn,
         oBlinkOn, oIncrement, oShift, oDDRAMAddr, oErrorFlags} !== {21'h0, 1'b1, 12'h0}) begin
      n_mis++;
      $display("FAIL reset_outputs: valid=%b byte=%h data=%b init=%b mode=%b addr=%h err=%b, want all 0 with incr=1",
               oByteValid, oByte, oIsData, oInitDone,
               {oTwoLine, oDisplayOn, oCursorOn, oBlinkOn, oIncrement, oShift}, oDDRAMAddr, oErrorFlags);
    end
    n_cmp++;
    if (oBusy !== 1'b1) begin n_mis++; $display("FAIL reset_busy: got %b want 1", oBusy); end
    tick(15);
    n_cmp++;
    if (oBusy !== 1'b1) begin n_mis++; $display("FAIL pwrup_busy_15: got %b want 1", oBusy); end
    tick(1);
    n_cmp++;
    if (oBusy !== 1'b0) begin n_mis++; $display("FAIL pwrup_busy_16: got %b want 0", oBusy); end
    tick(1);
    send_nibble(1'b0, 1'b0, 4'h3);
    n_cmp++;
    if (oBusy !== 1'b1) begin n_mis++; $display("FAIL init_nibble_busy: got %b want 1", oBusy); end
    tick(2);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h3);
    n_cmp++;
    if (oInitDone !== 1'b0) begin n_mis++; $display("FAIL init_after_3: got %b want 0", oInitDone); end
    tick(2);
    send_nibble(1'b0, 1'b0, 4'h2);
    n_cmp++;
    if ({oInitDone, oErrorFlags, oByteValid} !== {1'b1, 4'h0, 1'b0}) begin
      n_mis++;
      $display("FAIL init_done: init=%b err=%b valid=%b want 1 0000 0", oInitDone, oErrorFlags, oByteValid);
    end
    tick(2);
  endtask

  task automatic test_config();
    for (int i = 0; i < 5; i++) begin
      send_byte(1'b0, CFG_BYTE[i]);
      n_cmp++;
      if ({oByteValid, oByte, oIsData, oDDRAMAddr} !== {1'b1, CFG_BYTE[i], 1'b0, CFG_ADDR[i]}) begin
        n_mis++;
        $display("FAIL config_byte[%0d]: valid=%b byte=%h data=%b addr=%h want 1 %h 0 %h",
                 i, oByteValid, oByte, oIsData, oDDRAMAddr, CFG_BYTE[i], CFG_ADDR[i]);
      end
      tick(1);
      n_cmp++;
      if (oByteValid !== 1'b0) begin n_mis++; $display("FAIL config_pulse[%0d]: got %b want 0", i, oByteValid); end
      tick(8);
    end
    n_cmp++;
    if ({oTwoLine, oDisplayOn, oCursorOn, oBlinkOn, oIncrement, oShift, oErrorFlags} !== {6'b110010, 4'h0}) begin
      n_mis++;
      $display("FAIL config_shadow: mode=%b err=%b want 110010 0000",
               {oTwoLine, oDisplayOn, oCursorOn, oBlinkOn, oIncrement, oShift}, oErrorFlags);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 9; i++) begin
      send_byte(WR_RS[i], WR_BYTE[i]);
      n_cmp++;
      if ({oByteValid, oByte, oIsData, oDDRAMAddr, oIncrement} !==
          {1'b1, WR_BYTE[i], WR_RS[i], WR_ADDR[i], WR_INC[i]}) begin
        n_mis++;
        $display("FAIL wrap[%0d]: valid=%b byte=%h data=%b addr=%h incr=%b want 1 %h %b %h %b",
                 i, oByteValid, oByte, oIsData, oDDRAMAddr, oIncrement,
                 WR_BYTE[i], WR_RS[i], WR_ADDR[i], WR_INC[i]);
      end
      tick(2);
    end
  endtask

  task automatic test_busy_strobe();
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h0F);
    n_cmp++;
    if ({oErrorFlags, oByteValid, oByte, oDisplayOn, oCursorOn, oBlinkOn} !== {4'b0010, 1'b1, 8'h0F, 3'b111}) begin
      n_mis++;
      $display("FAIL busy_strobe: err=%b valid=%b byte=%h dcb=%b want 0010 1 0f 111",
               oErrorFlags, oByteValid, oByte, {oDisplayOn, oCursorOn, oBlinkOn});
    end
    tick(9);
  endtask

  task automatic test_read_strobe();
    send_nibble(1'b0, 1'b1, 4'h8);
    n_cmp++;
    if ({oErrorFlags, oByteValid} !== {4'b0110, 1'b0}) begin
      n_mis++;
      $display("FAIL read_strobe: err=%b valid=%b want 0110 0", oErrorFlags, oByteValid);
    end
    tick(1);
    send_byte(1'b0, 8'h8A);
    n_cmp++;
    if ({oByteValid, oByte, oDDRAMAddr} !== {1'b1, 8'h8A, 7'h0A}) begin
      n_mis++;
      $display("FAIL after_read: valid=%b byte=%h addr=%h want 1 8a 0a", oByteValid, oByte, oDDRAMAddr);
    end
    tick(2);
    send_byte(1'b0, 8'h30);
    n_cmp++;
    if ({oTwoLine, oErrorFlags, oInitDone} !== {1'b0, 4'b1110, 1'b1}) begin
      n_mis++;
      $display("FAIL func_set_dl: two=%b err=%b init=%b want 0 1110 1", oTwoLine, oErrorFlags, oInitDone);
    end
    tick(2);
  endtask

  task automatic test_early_strobe();
    do_reset();
    send_nibble(1'b0, 1'b0, 4'h3);
    n_cmp++;
    if ({oErrorFlags, oInitDone, oBusy} !== {4'b0001, 1'b0, 1'b1}) begin
      n_mis++;
      $display("FAIL early_strobe: err=%b init=%b busy=%b want 0001 0 1", oErrorFlags, oInitDone, oBusy);
    end
    tick(15);
    init_seq();
    n_cmp++;
    if ({oInitDone, oErrorFlags} !== {1'b1, 4'b0001}) begin
      n_mis++;
      $display("FAIL early_then_init: init=%b err=%b want 1 0001", oInitDone, oErrorFlags);
    end
  endtask

  task automatic test_init_error();
    do_reset();
    tick(17);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h5);
    n_cmp++;
    if ({oErrorFlags, oInitDone} !== {4'b1000, 1'b0}) begin
      n_mis++;
      $display("FAIL init_bad_nibble: err=%b init=%b want 1000 0", oErrorFlags, oInitDone);
    end
    tick(2);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h3); tick(2);
    send_nibble(1'b0, 1'b0, 4'h2); tick(2);
    n_cmp++;
    if (oInitDone !== 1'b0) begin n_mis++; $display("FAIL init_restart_3a: init=%b want 0", oInitDone); end
    init_seq();
    n_cmp++;
    if ({oInitDone, oErrorFlags} !== {1'b1, 4'b1000}) begin
      n_mis++;
      $display("FAIL init_recover: init=%b err=%b want 1 1000", oInitDone, oErrorFlags);
    end
  endtask

  task automatic test_reset_mid_byte();
    send_byte(1'b0, 8'h28);
    tick(2);
    send_nibble(1'b0, 1'b0, 4'h8);
    do_reset();
    n_cmp++;
    if ({oByteValid, oByte, oIsData, oInitDone, oTwoLine, oDisplayOn, oCursorOn,
         oBlinkOn, oIncrement, oShift, oDDRAMAddr, oErrorFlags, oBusy} !== {21'h0, 1'b1, 12'h0, 1'b1}) begin
      n_mis++;
      $display("FAIL mid_reset: valid=%b byte=%h init=%b mode=%b addr=%h err=%b busy=%b want 0 00 0 000010 00 0000 1",
               oByteValid, oByte, oInitDone,
               {oTwoLine, oDisplayOn, oCursorOn, oBlinkOn, oIncrement, oShift}, oDDRAMAddr, oErrorFlags, oBusy);
    end
    tick(17);
    init_seq();
    n_cmp++;
    if ({oInitDone, oErrorFlags} !== {1'b1, 4'h0}) begin
      n_mis++;
      $display("FAIL mid_reset_init: init=%b err=%b want 1 0000", oInitDone, oErrorFlags);
    end
    send_byte(1'b0, 8'h87);
    n_cmp++;
    if ({oByteValid, oByte, oDDRAMAddr, oErrorFlags} !== {1'b1, 8'h87, 7'h07, 4'h0}) begin
      n_mis++;
      $display("FAIL mid_reset_byte: valid=%b byte=%h addr=%h err=%b want 1 87 07 0000",
               oByteValid, oByte, oDDRAMAddr, oErrorFlags);
    end
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset                       = 1'b1;
    lcd_bus.iLCD_Enabled        = 1'b0;
    lcd_bus.iLCD_RegisterSelect = 1'b0;
    lcd_bus.iLCD_ReadWrite      = 1'b0;
    lcd_bus.iLCD_Data           = 4'h0;
    tick(2);
    test_reset();
    test_config();
    test_wrap();
    test_busy_strobe();
    test_read_strobe();
    test_early_strobe();
    test_init_error();
    test_reset_mid_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
